phy_rx_serial_align: RTL and testbench
======================================

// Module: phy_rx_serial_align
// PURPOSE
//  Receive end of the phy serial link: takes the 1-bit MSB-first stream at clk_8f and recovers byte alignment from COM (8'hBC).
//  Emits 8-bit bytes with a valid flag for the lane demultiplexer.
//  Mirrors the transmit serializer, which sends COM when its lane input is idle.
// PARAMETERS
//  COM        8'hBC  comma / idle character, used for alignment
//  LOCK_COUNT 4      consecutive aligned COMs needed to declare the link active (>=2)
// PORTS
//  clk_8f     in   1  serial bit clock; all logic on rising edge
//  reset      in   1  asynchronous, active-low; 0 = reset
//  data_in    in   1  serial bit, MSB of each byte first
//  data_out   out  8  recovered byte
//  valid_out  out  1  data_out holds a non-COM byte; one cycle per byte
//  byte_stb   out  1  1-cycle pulse on every aligned byte boundary while locked
//  active     out  1  link aligned and locked
// BEHAVIOUR
//  Reset (reset==0, async): state=SEARCH, shift=8'h00, bit_cnt=0, com_cnt=0.
//   Outputs: data_out=8'h00, valid_out=0, byte_stb=0, active=0.
//  Shift: every cycle, shift <= {shift[6:0], data_in}. Let nxt = {shift[6:0], data_in}.
//  SEARCH: compare nxt==COM every cycle (bit-sliding).
//   - On a match: bit_cnt<=0, com_cnt<=1, go to LOCKING. This edge is the byte boundary.
//  LOCKING: bit_cnt increments mod 8; the boundary is the edge where bit_cnt==7.
//   - At a boundary with nxt==COM: com_cnt++.
//   - If com_cnt reaches LOCK_COUNT, go to ACTIVE and set active<=1 on the same edge.
//   - At a boundary with nxt!=COM: go to SEARCH, com_cnt<=0. A match on that same edge is ignored.
//   - data_out, valid_out and byte_stb stay 0 throughout LOCKING.
//  ACTIVE: at each boundary, on the same edge:
//   - data_out<=nxt, byte_stb<=1, valid_out<=(nxt!=COM).
//   - Between boundaries: byte_stb=0, valid_out=0, data_out holds its value.
//   - Latency: 8th bit sampled at edge N, so the byte is visible after edge N (registered, one clk_8f).
//   - Alignment is never re-searched while ACTIVE. Only reset leaves ACTIVE.
//  COM bytes in ACTIVE: data_out=COM, valid_out=0, byte_stb=1 (idle, no data).
//  Reset asserted mid-byte: all state is cleared immediately. The partial byte is discarded, no output pulse.
//   After release, SEARCH restarts from an empty shift register.
//  bit_cnt is 3 bits and wraps 7->0 with no extra cycle.
//   com_cnt is wide enough for LOCK_COUNT and saturates at LOCK_COUNT.
//  Simultaneous events: a boundary that completes the lock count also asserts active on that edge.
//   That COM is not output. The first byte_stb comes 8 cycles later.
// STRUCTURE
//  Shared package phy_pkg: COM constant, state encoding (SEARCH=2'd0, LOCKING=2'd1, ACTIVE=2'd2).
//   The transmit serializer uses the same COM.
//  Sub-module rx_byte_shifter: 8-bit shift register plus 3-bit mod-8 bit_cnt with boundary flag.
//   It has a sync clear input, driven on SEARCH->LOCKING to realign the boundary.
//  Top level: FSM, com_cnt, output registers.
// TESTING
//  1. Reset held 0 for 5 cycles with data_in toggling -> all outputs 0, active=0.
//  2. After 3 junk bits, send BC,BC,BC,BC (32 bits) -> active rises on the edge of the 4th COM's last bit.
//     No valid_out during this sequence.
//  3. Locked, then send 8'hA5, 8'h3C, BC -> valid_out pulses with data_out=A5, then 3C.
//     For BC: byte_stb=1, valid_out=0, data_out=BC.
//  4. BC,BC, then 8'h55, then BC x4 -> back to SEARCH at the 55 boundary.
//     active rises only after the following 4 aligned COMs.
//  5. Locked, reset pulsed low for 1 cycle at bit 3 of byte 8'hF0 -> outputs cleared at once.
//     No F0 output; a fresh 4-COM lock is required.
//  6. Compare against the transmit serializer in loopback: lane bytes 00..FF with idles in between.
//     Every non-COM byte appears exactly once, in order, with valid_out=1.

Source files
------------

// File: rtl/phy_pkg.sv
// Shared definitions for the phy serial link: comma character and receive alignment states.
package phy_pkg;

  localparam logic [7:0] COM = 8'hBC;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    LOCKING = 2'd1,
    ACTIVE  = 2'd2
  } rx_state_e;

endpackage

// File: rtl/rx_byte_shifter.sv
// Serial-to-parallel shifter with a mod-8 bit counter; boundary marks the edge completing a byte.
module rx_byte_shifter (
  input  logic       clk_8f,
  input  logic       reset,
  input  logic       clr,
  input  logic       data_in,
  output logic [7:0] nxt,
  output logic       boundary
);

  logic [7:0] shift_q, shift_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;

  always_comb begin
    shift_d   = {shift_q[6:0], data_in};
    bit_cnt_d = clr ? 3'd0 : bit_cnt_q + 3'd1;
  end

  assign nxt      = shift_d;
  assign boundary = (bit_cnt_q == 3'd7);

  always_ff @(posedge clk_8f or negedge reset) begin
    if (!reset) begin
      shift_q   <= 8'h00;
      bit_cnt_q <= 3'd0;
    end else begin
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

endmodule

// File: rtl/phy_rx_serial_align.sv
// Receive side of the phy serial link: aligns the MSB-first bit stream on COM and emits bytes once locked.
module phy_rx_serial_align #(
  parameter logic [7:0] COM        = phy_pkg::COM,
  parameter int         LOCK_COUNT = 4
) (
  input  logic       clk_8f,
  input  logic       reset,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       byte_stb,
  output logic       active
);

  import phy_pkg::*;

  localparam int CNT_W = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0] LOCK_N = CNT_W'(LOCK_COUNT);

  logic [7:0] nxt;
  logic       boundary;
  logic       clr;

  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] com_cnt_q, com_cnt_d;
  logic [7:0]       data_out_q, data_out_d;
  logic             valid_q, valid_d;
  logic             stb_q, stb_d;
  logic             active_q, active_d;

  rx_byte_shifter u_shifter (
    .clk_8f   (clk_8f),
    .reset    (reset),
    .clr      (clr),
    .data_in  (data_in),
    .nxt      (nxt),
    .boundary (boundary)
  );

  always_comb begin
    state_d    = state_q;
    com_cnt_d  = com_cnt_q;
    data_out_d = data_out_q;
    valid_d    = 1'b0;
    stb_d      = 1'b0;
    active_d   = active_q;
    clr        = 1'b0;
    unique case (state_q)
      SEARCH: begin
        // Bit-sliding: any edge where the window holds COM becomes the byte boundary.
        if (nxt == COM) begin
          clr       = 1'b1;
          com_cnt_d = CNT_W'(1);
          state_d   = LOCKING;
        end
      end
      LOCKING: begin
        if (boundary) begin
          if (nxt == COM) begin
            if (com_cnt_q != LOCK_N) com_cnt_d = com_cnt_q + CNT_W'(1);
            if (com_cnt_q + CNT_W'(1) >= LOCK_N) begin
              state_d  = ACTIVE;
              active_d = 1'b1;
            end
          end else begin
            com_cnt_d = '0;
            state_d   = SEARCH;
          end
        end
      end
      ACTIVE: begin
        // Alignment is trusted once locked; only reset leaves this state.
        if (boundary) begin
          data_out_d = nxt;
          stb_d      = 1'b1;
          valid_d    = (nxt != COM);
        end
      end
      default: begin
        com_cnt_d = '0;
        state_d   = SEARCH;
      end
    endcase
  end

  always_ff @(posedge clk_8f or negedge reset) begin
    if (!reset) begin
      state_q    <= SEARCH;
      com_cnt_q  <= '0;
      data_out_q <= 8'h00;
      valid_q    <= 1'b0;
      stb_q      <= 1'b0;
      active_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      com_cnt_q  <= com_cnt_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      stb_q      <= stb_d;
      active_q   <= active_d;
    end
  end

  assign data_out  = data_out_q;
  assign valid_out = valid_q;
  assign byte_stb  = stb_q;
  assign active    = active_q;

endmodule

// File: tb/tb_phy_rx_serial_align.sv
// Scoreboard bench for phy_rx_serial_align: drives serial bytes and checks recovered bytes in order.
module tb_phy_rx_serial_align;

  localparam logic [7:0] COM_B = 8'hBC;

  logic       clk_8f = 1'b0;
  logic       reset  = 1'b0;
  logic       data_in = 1'b0;
  logic [7:0] data_out;
  logic       valid_out;
  logic       byte_stb;
  logic       active;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] d;
    logic       v;
  } exp_t;

  exp_t exp_q[$];
  logic [7:0] last_data = 8'h00;

  phy_rx_serial_align dut (
    .clk_8f    (clk_8f),
    .reset     (reset),
    .data_in   (data_in),
    .data_out  (data_out),
    .valid_out (valid_out),
    .byte_stb  (byte_stb),
    .active    (active)
  );

  always #5 clk_8f = ~clk_8f;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", tag, act, exp, $time);
    end
  endtask

  // Output monitor: every strobe must match the head of the expected queue.
  always @(negedge clk_8f) begin
    if (byte_stb) begin
      if (exp_q.size() == 0) begin
        chk("stb_unexpected", {24'h0, data_out}, 32'h100);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("data_out", {24'h0, data_out}, {24'h0, e.d});
        chk("valid_out", {31'h0, valid_out}, {31'h0, e.v});
      end
    end else if (reset) begin
      if (valid_out) chk("valid_without_stb", 32'h1, 32'h0);
      if (data_out !== last_data) chk("data_hold", {24'h0, data_out}, {24'h0, last_data});
    end
    last_data = data_out;
  end

  task automatic send_byte(input logic [7:0] b, input bit expect_out);
    if (expect_out) begin
      exp_t e;
      e.d = b;
      e.v = (b != COM_B);
      exp_q.push_back(e);
    end
    for (int i = 7; i >= 0; i--) begin
      data_in = b[i];
      @(posedge clk_8f);
      #1;
    end
  endtask

  task automatic send_bit(input logic b);
    data_in = b;
    @(posedge clk_8f);
    #1;
  endtask

  task automatic drain(input string tag);
    @(negedge clk_8f);
    #1;
    chk(tag, exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    // Test 1: reset held with toggling input
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      data_in = i[0];
      @(posedge clk_8f);
      #1;
    end
    chk("rst_data_out", {24'h0, data_out}, 32'h0);
    chk("rst_valid", {31'h0, valid_out}, 32'h0);
    chk("rst_stb", {31'h0, byte_stb}, 32'h0);
    chk("rst_active", {31'h0, active}, 32'h0);
    @(negedge clk_8f);
    #1;
    reset = 1'b1;

    // Test 2: junk bits then four COMs
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    for (int k = 0; k < 3; k++) send_byte(COM_B, 1'b0);
    chk("lock_early_active", {31'h0, active}, 32'h0);
    send_byte(COM_B, 1'b0);
    chk("lock_active", {31'h0, active}, 32'h1);
    drain("lock_no_output");

    // Test 3: data bytes while locked
    send_byte(8'hA5, 1'b1);
    send_byte(8'h3C, 1'b1);
    send_byte(COM_B, 1'b1);
    drain("data_drain");
    chk("data_last", {24'h0, data_out}, {24'h0, COM_B});

    // Test 5: reset mid-byte of F0
    for (int i = 7; i >= 4; i--) send_bit(1'(8'hF0 >> i));
    data_in = 1'b0;
    reset = 1'b0;
    #1;
    chk("midrst_data_out", {24'h0, data_out}, 32'h0);
    chk("midrst_active", {31'h0, active}, 32'h0);
    chk("midrst_stb", {31'h0, byte_stb}, 32'h0);
    @(posedge clk_8f);
    @(negedge clk_8f);
    #1;
    reset = 1'b1;
    for (int i = 2; i >= 0; i--) send_bit(1'b0);
    send_byte(COM_B, 1'b0);
    chk("relock_not_single", {31'h0, active}, 32'h0);

    // Test 4: lock broken by 55, then a fresh four-COM lock
    send_byte(COM_B, 1'b0);
    send_byte(8'h55, 1'b0);
    for (int k = 0; k < 3; k++) send_byte(COM_B, 1'b0);
    chk("relock_early_active", {31'h0, active}, 32'h0);
    send_byte(COM_B, 1'b0);
    chk("relock_active", {31'h0, active}, 32'h1);
    drain("relock_no_output");

    // Test 6: serializer-style loopback, idle COM between lane bytes
    for (int b = 0; b < 256; b++) begin
      send_byte(COM_B, 1'b1);
      send_byte(8'(b), 1'b1);
    end
    drain("loopback_drain");
    chk("loopback_active", {31'h0, active}, 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
